// File: rtl/rc_pwm_encoder_pkg.sv
// Shared constants, state encoding and helpers for the RC PWM encoder.
package rc_pwm_encoder_pkg;

  // Default pulse timing constants, shared with the receiver-side decoder.
  localparam int unsigned REC_VAL_W_DEF       = 8;
  localparam int unsigned MIN_PULSE_US_DEF    = 1000;
  localparam int unsigned SCALE_US_DEF        = 4;
  localparam int unsigned GAP_US_DEF          = 0;
  localparam int unsigned FRAME_PERIOD_US_DEF = 20000;

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned NUM_CH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_WAIT
  } enc_state_e;

  // Pulse length in microseconds for a channel value; no wrap inside 16 bits.
  function automatic logic [TIMER_W-1:0] pulse_len(input int unsigned val,
                                                   input int unsigned min_us,
                                                   input int unsigned scale_us);
    return TIMER_W'(min_us + val * scale_us);
  endfunction

  // One-hot output mask for a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    return NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/rc_pulse_timer.sv
// Loadable down-counter; done is a registered strobe on the last cycle of the count.
module rc_pulse_timer
  import rc_pwm_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  // Count down from the loaded value; done is high while one cycle remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= count;
      done <= (count == TIMER_W'(1));
    end else if (cnt != '0) begin
      cnt  <= cnt - TIMER_W'(1);
      done <= (cnt == TIMER_W'(2));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/rc_pwm_encoder.sv
// Four-channel RC PWM encoder: emits one servo pulse per channel per frame, in sequence.
module rc_pwm_encoder
  import rc_pwm_encoder_pkg::*;
#(
  parameter int unsigned REC_VAL_BIT_WIDTH = REC_VAL_W_DEF,
  parameter int unsigned MIN_PULSE_US      = MIN_PULSE_US_DEF,
  parameter int unsigned SCALE_US          = SCALE_US_DEF,
  parameter int unsigned GAP_US            = GAP_US_DEF,
  parameter int unsigned FRAME_PERIOD_US   = FRAME_PERIOD_US_DEF
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] yaw_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] roll_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] pitch_val,
  output logic                         throttle_pwm,
  output logic                         yaw_pwm,
  output logic                         roll_pwm,
  output logic                         pitch_pwm,
  output logic                         frame_strobe,
  output logic                         busy
);

  localparam int unsigned VW    = REC_VAL_BIT_WIDTH;
  localparam int unsigned FCW   = $clog2(FRAME_PERIOD_US);
  localparam int unsigned WORST = 4 * (MIN_PULSE_US + ((32'd1 << VW) - 32'd1) * SCALE_US)
                                  + 3 * GAP_US;

  // A full frame of maximum-width pulses must fit inside the frame period.
  if (WORST >= FRAME_PERIOD_US) begin : g_frame_too_short
    $error("rc_pwm_encoder: worst-case pulse train does not fit in FRAME_PERIOD_US");
  end

  enc_state_e          state, state_d;
  logic [1:0]          ch, ch_d, ch_nxt;
  logic [NUM_CH-1:0]   pwm, pwm_d;
  logic                strobe_d, busy_d;
  logic [FCW-1:0]      frame_cnt;
  logic [VW-1:0]       vals [NUM_CH];
  logic                start, stop;
  logic                tmr_load, tmr_done;
  logic [TIMER_W-1:0]  tmr_count;

  assign ch_nxt = ch + 2'd1;

  rc_pulse_timer u_timer (
    .clk   (us_clk),
    .rst_n (resetn),
    .load  (tmr_load),
    .count (tmr_count),
    .done  (tmr_done)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state;
    ch_d      = ch;
    pwm_d     = pwm;
    strobe_d  = 1'b0;
    busy_d    = busy;
    tmr_load  = 1'b0;
    tmr_count = '0;
    start     = 1'b0;
    stop      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) start = 1'b1;
      end
      ST_PULSE: begin
        if (tmr_done) begin
          pwm_d = '0;
          if (ch == 2'd3) begin
            state_d = ST_WAIT;
          end else if (GAP_US != 0) begin
            state_d   = ST_GAP;
            tmr_load  = 1'b1;
            tmr_count = TIMER_W'(GAP_US);
          end else begin
            // Zero gap: next channel rises on the edge this one falls.
            ch_d      = ch_nxt;
            pwm_d     = ch_onehot(ch_nxt);
            tmr_load  = 1'b1;
            tmr_count = pulse_len(32'(vals[ch_nxt]), MIN_PULSE_US, SCALE_US);
          end
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d   = ST_PULSE;
          ch_d      = ch_nxt;
          pwm_d     = ch_onehot(ch_nxt);
          tmr_load  = 1'b1;
          tmr_count = pulse_len(32'(vals[ch_nxt]), MIN_PULSE_US, SCALE_US);
        end
      end
      ST_WAIT: begin
        if (frame_cnt == FCW'(FRAME_PERIOD_US - 1)) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            stop    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: throttle pulse begins from the live input value being latched.
    if (start) begin
      state_d   = ST_PULSE;
      ch_d      = 2'd0;
      pwm_d     = ch_onehot(2'd0);
      strobe_d  = 1'b1;
      busy_d    = 1'b1;
      tmr_load  = 1'b1;
      tmr_count = pulse_len(32'(throttle_val), MIN_PULSE_US, SCALE_US);
    end
  end

  // State and registered outputs.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      ch           <= '0;
      pwm          <= '0;
      frame_strobe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      ch           <= ch_d;
      pwm          <= pwm_d;
      frame_strobe <= strobe_d;
      busy         <= busy_d;
    end
  end

  // Frame position counter and value latch, both restarted at each frame start.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) vals[i] <= '0;
    end else begin
      if (start || stop) begin
        frame_cnt <= '0;
      end else if (busy) begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
      if (start) begin
        vals[0] <= throttle_val;
        vals[1] <= yaw_val;
        vals[2] <= roll_val;
        vals[3] <= pitch_val;
      end
    end
  end

  assign throttle_pwm = pwm[0];
  assign yaw_pwm      = pwm[1];
  assign roll_pwm     = pwm[2];
  assign pitch_pwm    = pwm[3];

endmodule

// File: tb/tb_rc_pwm_encoder.sv
// Bench for rc_pwm_encoder: three configurations against a frame-timeline model.
module tb_rc_pwm_encoder;

  localparam int NI = 3;
  localparam int P_MIN [NI] = '{1000, 1000, 20};
  localparam int P_SCL [NI] = '{4, 4, 1};
  localparam int P_GAP [NI] = '{0, 50, 3};
  localparam int P_FP  [NI] = '{20000, 20000, 1200};

  logic       clk    = 1'b0;
  logic       resetn = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] thr = '0, yaw = '0, rol = '0, pit = '0;

  // obs bits: 0 busy, 1 frame_strobe, 2 throttle, 3 yaw, 4 roll, 5 pitch
  logic [5:0] obs [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic t_p, y_p, r_p, p_p, fs, bz;
    rc_pwm_encoder #(
      .REC_VAL_BIT_WIDTH (8),
      .MIN_PULSE_US      (P_MIN[g]),
      .SCALE_US          (P_SCL[g]),
      .GAP_US            (P_GAP[g]),
      .FRAME_PERIOD_US   (P_FP[g])
    ) u_dut (
      .us_clk       (clk),
      .resetn       (resetn),
      .enable       (enable),
      .throttle_val (thr),
      .yaw_val      (yaw),
      .roll_val     (rol),
      .pitch_val    (pit),
      .throttle_pwm (t_p),
      .yaw_pwm      (y_p),
      .roll_pwm     (r_p),
      .pitch_pwm    (p_p),
      .frame_strobe (fs),
      .busy         (bz)
    );
    assign obs[g] = {p_p, r_p, y_p, t_p, fs, bz};
  end

  // ---------------- behavioural model: frame offset + latched values ----------------
  bit m_busy [NI];
  int m_off  [NI];
  int m_lat  [NI][4];

  task automatic start_frame(input int i);
    m_busy[i]   = 1'b1;
    m_off[i]    = 0;
    m_lat[i][0] = int'(thr);
    m_lat[i][1] = int'(yaw);
    m_lat[i][2] = int'(rol);
    m_lat[i][3] = int'(pit);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 1'b0;
      m_off[i]  = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (!resetn) begin
          m_busy[i] = 1'b0;
          m_off[i]  = 0;
        end else if (!m_busy[i]) begin
          if (enable) start_frame(i);
        end else begin
          m_off[i]++;
          if (m_off[i] == P_FP[i]) begin
            if (enable) start_frame(i);
            else m_busy[i] = 1'b0;
          end
        end
      end
    end
  end

  // Expected outputs from the pulse timeline: channel c is high over [rise_c, rise_c+N_c).
  function automatic logic [5:0] expect_out(input int i);
    logic [3:0] pw;
    int rise, n;
    if (!resetn || !m_busy[i]) return 6'd0;
    pw   = '0;
    rise = 0;
    for (int c = 0; c < 4; c++) begin
      n = P_MIN[i] + m_lat[i][c] * P_SCL[i];
      if (m_off[i] >= rise && m_off[i] < rise + n) pw[c] = 1'b1;
      rise += n + P_GAP[i];
    end
    return {pw, (m_off[i] == 0), 1'b1};
  endfunction

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        logic [5:0] e;
        e = expect_out(i);
        total++;
        if (obs[i] !== e) begin
          bad++;
          $display("FAIL cycle_cmp inst%0d cyc=%0d got=%b want=%b", i, cyc, obs[i], e);
        end
      end
    end
  end

  // ---------------- edge monitor for directed literal checks ----------------
  int   rise_t   [NI][4];
  int   wid      [NI][4];
  int   prev_thr [NI];
  logic prev_lv  [NI][4];

  initial begin
    for (int i = 0; i < NI; i++) begin
      prev_thr[i] = 0;
      for (int c = 0; c < 4; c++) begin
        prev_lv[i][c] = 1'b0;
        rise_t[i][c]  = 0;
        wid[i][c]     = 0;
      end
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        for (int c = 0; c < 4; c++) begin
          logic lv;
          lv = obs[i][2+c];
          if (lv && !prev_lv[i][c]) begin
            if (c == 0) prev_thr[i] = rise_t[i][0];
            rise_t[i][c] = cyc;
          end
          if (!lv && prev_lv[i][c]) wid[i][c] = cyc - rise_t[i][c];
          prev_lv[i][c] = lv;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Wait until instance 0 is busy at the given frame offset, bounded.
  task automatic wait_off(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (!(m_busy[0] && m_off[0] == n) && k < 25000) begin
      @(negedge clk);
      k++;
    end
    if (!(m_busy[0] && m_off[0] == n)) begin
      total++;
      bad++;
      $display("FAIL wait_off got=timeout want=offset_%0d", n);
    end
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int exp_w [4];
    int exp_r [4];

    #1;
    resetn = 1'b0;
    enable = 1'b1;
    {thr, yaw, rol, pit} = {8'd5, 8'd6, 8'd7, 8'd8};
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outs_inst0", int'(obs[0]), 0);
    chk("reset_outs_inst1", int'(obs[1]), 0);

    // Release: throttle rises one cycle after the first enabled edge.
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("pre_start_thr", int'(obs[0][2]), 0);
    @(posedge clk);
    @(negedge clk); #1;
    chk("first_thr", int'(obs[0][2]), 1);
    chk("first_strobe", int'(obs[0][1]), 1);
    chk("first_busy", int'(obs[0][0]), 1);
    @(negedge clk); #1;
    chk("strobe_one_cycle", int'(obs[0][1]), 0);

    // Reset in the middle of the yaw pulse.
    wait_off(1500);
    @(posedge clk); #2;
    chk("yaw_before_rst", int'(obs[0][3]), 1);
    resetn = 1'b0;
    #1;
    chk("rst_async_yaw", int'(obs[0][3]), 0);
    chk("rst_async_all", int'(obs[0]), 0);
    {thr, yaw, rol, pit} = {8'd10, 8'd20, 8'd30, 8'd40};
    @(posedge clk); #2;
    resetn = 1'b1;

    // Sequencing frame with a mid-frame throttle change.
    wait_off(500);
    @(posedge clk); #2;
    thr = 8'd200;
    wait_off(5000);
    exp_w = '{1040, 1080, 1120, 1160};
    exp_r = '{0, 1090, 2220, 3390};
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("seq_width_ch%0d", c), wid[1][c], exp_w[c]);
      chk($sformatf("seq_rise_ch%0d", c), rise_t[1][c] - rise_t[1][0], exp_r[c]);
    end
    chk("gap0_yaw_on_thr_fall", rise_t[0][1], rise_t[0][0] + wid[0][0]);

    // Next frame picks up the changed throttle value.
    wait_off(2000);
    chk("frame_period", rise_t[1][0] - prev_thr[1], 20000);
    chk("new_thr_width", wid[0][0], 1800);
    {thr, yaw, rol, pit} = '0;

    // All-zero frame, enable dropped during the roll pulse.
    wait_off(0);
    wait_off(2500);
    enable = 1'b0;
    wait_off(4100);
    for (int c = 0; c < 4; c++) chk($sformatf("zero_width_ch%0d", c), wid[0][c], 1000);
    wait_off(19999);
    chk("busy_last_cycle", int'(obs[0][0]), 1);
    @(negedge clk); #1;
    chk("busy_dropped", int'(obs[0][0]), 0);

    // Re-enable with all-max values.
    repeat (50) @(posedge clk);
    #2;
    {thr, yaw, rol, pit} = {8'd255, 8'd255, 8'd255, 8'd255};
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("reenable_thr", int'(obs[0][2]), 1);
    wait_off(8100);
    for (int c = 0; c < 4; c++) chk($sformatf("max_width_ch%0d", c), wid[0][c], 2020);

    // Random values, enable toggles and occasional resets.
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #2;
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 1999) == 0) resetn = 1'b0;
      if ($urandom_range(0, 39) == 0) {thr, yaw, rol, pit} = $urandom;
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc_pwm_encoder.md
# rc_pwm_encoder

Four-channel RC PWM encoder: the transmit-side counterpart of `receiver`. Converts 8-bit throttle/yaw/roll/pitch values into servo-style pulses, one pulse per channel per frame, emitted sequentially like a real RC receiver output. It is used as an on-board loopback stimulus source for `receiver` during bench and flight-controller bring-up, and runs on the 1 µs `us_clk` domain.

## Interface
Parameters:
- `REC_VAL_BIT_WIDTH`, 8: channel value width.
- `MIN_PULSE_US`, 1000: pulse width in µs for value 0.
- `SCALE_US`, 4: µs added per LSB. Value 255 gives 2020 µs.
- `GAP_US`, 0: low time in µs between the falling edge of channel n and the rising edge of channel n+1.
- `FRAME_PERIOD_US`, 20000: frame length in µs, from one throttle rising edge to the next.

Ports (one clock, `us_clk`; reset `resetn` is asynchronous and active-low):
- `us_clk`, in, 1: 1 MHz tick clock.
- `resetn`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: start and continue framing.
- `throttle_val`, in, REC_VAL_BIT_WIDTH: channel 0 value.
- `yaw_val`, in, REC_VAL_BIT_WIDTH: channel 1 value.
- `roll_val`, in, REC_VAL_BIT_WIDTH: channel 2 value.
- `pitch_val`, in, REC_VAL_BIT_WIDTH: channel 3 value.
- `throttle_pwm`, out, 1: channel 0 pulse output.
- `yaw_pwm`, out, 1: channel 1 pulse output.
- `roll_pwm`, out, 1: channel 2 pulse output.
- `pitch_pwm`, out, 1: channel 3 pulse output.
- `frame_strobe`, out, 1: one-cycle pulse on the first cycle of each frame.
- `busy`, out, 1: high while a frame is in progress.

## Operation
- States: IDLE, PULSE, GAP, WAIT. A 2-bit channel index `ch` runs 0..3.
- **IDLE** with `enable=1` at an edge:
  - Latch all four values.
  - Set `frame_cnt` to 0 and `ch` to 0.
  - Go to PULSE and register `throttle_pwm=1`, `frame_strobe=1` and `busy=1`.
- **PULSE**: the selected output is high for exactly N = MIN_PULSE_US + val×SCALE_US cycles. This is computed at 16 bits with no wrap.
- **End of pulse**:
  - If `ch<3` and GAP_US>0, go to GAP.
  - If `ch<3` and GAP_US=0, the next channel rises on the same edge the current one falls.
  - If `ch=3`, go to WAIT.
- **GAP**: all outputs low for GAP_US cycles. Then increment `ch` and go to PULSE.
- **WAIT**: all outputs low until `frame_cnt = FRAME_PERIOD_US-1`.
  - At that edge, if `enable=1`, start a new frame exactly as from IDLE (the frame is back-to-back).
  - Otherwise go to IDLE and drop `busy` to 0.
- `frame_cnt` runs on every cycle while `busy=1`. Its width is $clog2(FRAME_PERIOD_US) and it resets to 0 at each frame start.
- Value inputs are sampled only at frame start. Changes mid-frame have no effect until the next frame.
- `enable` falling mid-frame does not truncate anything: the frame completes, then the block goes to IDLE.
- At most one pwm output is high at any time.
- Elaboration check: 4×(MIN_PULSE_US+(2^REC_VAL_BIT_WIDTH−1)×SCALE_US)+3×GAP_US < FRAME_PERIOD_US. A violation is a `$error`.

## Timing
- Reset values: all pwm outputs 0, `frame_strobe` 0, `busy` 0, state IDLE, counters 0, latched values 0.
- Reset asserted mid-pulse forces all outputs low immediately (asynchronously). No partial frame resumes after release.
- Latency: `throttle_pwm` rises 1 cycle after the edge where `enable` is sampled high in IDLE.
- Rising-edge offsets within a frame:
  - Channel 0: 0.
  - Channel k: sum of N over the prior channels + k×GAP_US.
- All outputs are registered, so outputs are glitch-free.

## Structure
- Defaults for MIN_PULSE_US, SCALE_US and FRAME_PERIOD_US go in `common_defines.v`, so `receiver` decodes against the same constants.
- Natural sub-module: `rc_pulse_timer`, a loadable down-counter.
  - Inputs: `load` and `count[15:0]`.
  - Output: `done` strobe.
  - Used for both PULSE and GAP durations.

## Test plan
- **Reset**: hold `resetn=0` with `enable=1` → all outputs 0 and `busy=0`. Release → `throttle_pwm` rises 1 cycle after the first enabled edge, with `frame_strobe` high for 1 cycle.
- **Extremes**: all values 0 → each pulse is 1000 cycles. All values 255 → each pulse is 2020 cycles. With GAP_US=0, yaw rises on the cycle throttle falls.
- **Sequencing**: throttle=10, yaw=20, roll=30, pitch=40, GAP_US=50 → widths 1040/1080/1120/1160. Rising offsets 0/1090/2220/3390. Next throttle rise at cycle 20000.
- **Mid-frame change**: change throttle from 10 to 200 at cycle 500 → current pulse stays 1040. The next frame's pulse is 1800.
- **Enable drop**: deassert `enable` during the roll pulse → frame completes normally, `busy` falls after cycle 19999, no further pulses. Re-assert → new frame starts 1 cycle later.
- **Reset mid-pulse**: assert `resetn=0` during the yaw pulse → `yaw_pwm` drops asynchronously. After release with `enable=1`, the frame restarts at throttle with freshly latched values.
